bias_stream_buf: RTL and testbench
==================================

// Module: bias_stream_buf
// PURPOSE
//  Parametrised bias buffer: single-port SRAM store with a host write port and a
//  burst read engine that streams BURST_LEN words from a base address to the PE
//  array over a valid/ready interface with full backpressure. It replaces
//  fixed-size bias macros in the CNN datapath. Supports byte-masked writes,
//  address wrap-around and 1 word/cycle sustained throughput.
// PARAMETERS
//  DATA_W   32                 word width, bits; multiple of 8
//  DEPTH    384                words stored
//  ADDR_W   $clog2(DEPTH)      address width
//  LEN_W    ADDR_W+1           burst-length width; allows length == DEPTH
// PORTS
//  CK         in   1         clock; single clock domain
//  RST        in   1         synchronous, active-high reset
//  wr_valid   in   1         host write request
//  wr_ready   out  1         write accepted when wr_valid&&wr_ready
//  wr_addr    in   ADDR_W    write address (< DEPTH)
//  wr_data    in   DATA_W    write data
//  wr_be      in   DATA_W/8  byte enables; bit i covers data[8i+7:8i]
//  start      in   1         burst start; accepted only in IDLE
//  base_addr  in   ADDR_W    first read address
//  burst_len  in   LEN_W     words to stream; 0 is legal
//  busy       out  1         high in STREAM and FLUSH
//  done       out  1         one-cycle pulse when the burst completes
//  o_valid    out  1         stream data valid
//  o_ready    in   1         stream consumer ready
//  o_data     out  DATA_W    stream data
// BEHAVIOUR
//  - Reset: state=IDLE; wr_ready=0, busy=0, done=0, o_valid=0, o_data=0.
//    FIFO and counters are cleared. SRAM contents are NOT cleared. RST during
//    a burst aborts it and gives no done pulse.
//  - FSM IDLE -> STREAM on start. STREAM -> FLUSH when the last read is issued.
//    FLUSH -> IDLE when the last beat handshakes; done pulses in that same cycle.
//    A start with burst_len==0: done pulses in the next cycle, no beats are sent,
//    and the FSM stays in IDLE.
//  - wr_ready = (state==IDLE) && !start. The burst wins when start and wr_valid
//    are both high in one cycle. Accepted writes update only the enabled bytes
//    at the next CK edge.
//  - SRAM: one port, 1-cycle read latency. A write while reading the same address
//    cannot occur, because writes are IDLE-only.
//  - Read engine: rd_addr starts at base_addr and increments per issued read.
//    It wraps DEPTH-1 -> 0, which is not a power of 2 for the default. Remaining
//    length counts down to 0.
//  - Flow control: a 2-entry output FIFO. A read issues when
//    occ + inflight - pop < 2, where pop = o_valid && o_ready in the same cycle.
//    The FIFO never overflows. Data is captured at the end of the cycle after
//    the issue.
//  - Latency: start accepted in cycle 0 -> first read in cycle 1 -> o_valid=1 in
//    cycle 3 with o_data=mem[base_addr]. With o_ready held at 1: one beat per
//    cycle, and the last beat is in cycle burst_len+2.
//  - Stream rules: o_data stays stable while o_valid && !o_ready. o_valid does not
//    drop without a handshake. Beats come out in address order.
//  - start while busy is ignored. burst_len > DEPTH is clamped to DEPTH.
// STRUCTURE
//  - bias_buf_pkg holds:
//    - state_e {IDLE, STREAM, FLUSH};
//    - localparam BYTES = DATA_W/8;
//    - function next_addr(addr) with the wrap rule.
//  - Sub-module sp_sram_be (DATA_W, DEPTH): behavioural single-port SRAM with
//    CS/WEB/byte-enable and a registered DO. It is the single swap point for the
//    foundry macro.
//  - Top level contains the FSM, counters, credit logic and a 2-entry FIFO,
//    all inline.
// TESTING
//  - Write mem[0..7]=i*0x11111111 (be all 1s); start base=0 len=8, o_ready=1
//    -> o_valid in cycle 3, 8 beats back-to-back, data matches, done pulse with
//    the last beat.
//  - Byte mask: write 0xAABBCCDD to addr 5, then 0x11223344 with be=4'b0101
//    -> a burst read of addr 5 returns 0xAA22CC44.
//  - Wrap: base=382, len=4 -> beats from addr 382, 383, 0, 1.
//  - Backpressure: o_ready random at 50% on a 16-beat burst -> no lost or
//    duplicated beats, o_data stable while stalled, done exactly once.
//  - len=0 -> done one cycle after start, o_valid never rises.
//  - Start+write collision: wr_ready=0 that cycle, write retried after done.
//  - RST asserted mid-burst -> all outputs 0 next cycle, no done; a re-burst
//    returns the stored data intact.

Source files
------------

// File: rtl/bias_buf_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bias_buf_pkg
// Description : Shared types and helpers for the bias stream buffer.
//               - state_e   : burst engine states
//               - BYTES     : byte lanes of the default 32-bit word
//               - next_addr : address increment with wrap at DEPTH-1
// Revision    : 1.0 - initial release
// ============================================================================
package bias_buf_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        FLUSH  = 2'd2
    } state_e;

    localparam int DATA_W_DEF = 32;
    localparam int BYTES      = DATA_W_DEF / 8;

    // DEPTH need not be a power of two, so the wrap is an explicit compare
    // rather than a natural overflow of the address register.
    function automatic int unsigned next_addr(input int unsigned addr,
                                              input int unsigned depth);
        return (addr == depth - 1) ? 0 : addr + 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sp_sram_be.sv
`default_nettype none
// ============================================================================
// Module      : sp_sram_be
// Description : Behavioural single-port SRAM, byte-write enables, registered
//               read data (1-cycle latency). Drop-in point for a foundry macro.
// Ports       : clk     - clock
//               i_cs    - chip select (access this cycle)
//               i_web   - write enable, active low (0 = write, 1 = read)
//               i_be    - byte enables, bit i covers data[8i+7:8i]
//               i_addr  - word address
//               i_wdata - write data
//               o_rdata - read data, valid the cycle after a read access
// Revision    : 1.0 - initial release
// ============================================================================
module sp_sram_be #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 384
) (
    input  logic                       clk,
    input  logic                       i_cs,
    input  logic                       i_web,
    input  logic [DATA_W/8-1:0]        i_be,
    input  logic [$clog2(DEPTH)-1:0]   i_addr,
    input  logic [DATA_W-1:0]          i_wdata,
    output logic [DATA_W-1:0]          o_rdata
);

    localparam int c_BYTES = DATA_W / 8;

    logic [DATA_W-1:0] r_mem [0:DEPTH-1];
    logic [DATA_W-1:0] r_rdata;

    // Read data holds its last value across writes and idle cycles, like
    // a typical macro output latch.
    always_ff @(posedge clk) begin
        if (i_cs) begin
            if (!i_web) begin
                for (int b = 0; b < c_BYTES; b++) begin
                    if (i_be[b]) begin
                        r_mem[i_addr][8*b +: 8] <= i_wdata[8*b +: 8];
                    end
                end
            end else begin
                r_rdata <= r_mem[i_addr];
            end
        end
    end

    assign o_rdata = r_rdata;

endmodule
`default_nettype wire

// File: rtl/bias_stream_buf.sv
`default_nettype none
// ============================================================================
// Module      : bias_stream_buf
// Description : Bias buffer. Host writes words (byte-masked) while idle; a
//               burst engine streams burst_len words from base_addr, wrapping
//               at DEPTH-1, over a valid/ready stream with full backpressure.
// Ports       : CK, RST              - clock, synchronous active-high reset
//               wr_valid/wr_ready    - host write handshake (IDLE only)
//               wr_addr/wr_data/wr_be- host write address, data, byte enables
//               start/base_addr/burst_len - burst request (IDLE only)
//               busy                 - burst in progress
//               done                 - one-cycle burst completion pulse
//               o_valid/o_ready/o_data - output stream
// Revision    : 1.0 - initial release
// ============================================================================
module bias_stream_buf
    import bias_buf_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 384,
    parameter int ADDR_W = $clog2(DEPTH),
    parameter int LEN_W  = ADDR_W + 1
) (
    input  logic                CK,
    input  logic                RST,
    input  logic                wr_valid,
    output logic                wr_ready,
    input  logic [ADDR_W-1:0]   wr_addr,
    input  logic [DATA_W-1:0]   wr_data,
    input  logic [DATA_W/8-1:0] wr_be,
    input  logic                start,
    input  logic [ADDR_W-1:0]   base_addr,
    input  logic [LEN_W-1:0]    burst_len,
    output logic                busy,
    output logic                done,
    output logic                o_valid,
    input  logic                o_ready,
    output logic [DATA_W-1:0]   o_data
);

    localparam logic [LEN_W-1:0] c_DEPTH_LEN = LEN_W'(DEPTH);

    state_e              r_state;
    state_e              w_state_next;

    logic [ADDR_W-1:0]   r_rd_addr;
    logic [LEN_W-1:0]    r_remain;
    logic                r_inflight;
    logic [1:0]          r_occ;
    logic                r_wr_ptr;
    logic                r_rd_ptr;
    logic [DATA_W-1:0]   r_fifo [0:1];
    logic                r_zero_done;

    logic                w_start_ok;
    logic [LEN_W-1:0]    w_len_eff;
    logic                w_wr_fire;
    logic                w_pop;
    logic [2:0]          w_credit_used;
    logic                w_issue;
    logic                w_last_issue;
    logic                w_last_beat;
    logic [DATA_W-1:0]   w_sram_rdata;

    assign w_start_ok = (r_state == IDLE) && start;
    assign w_len_eff  = (burst_len > c_DEPTH_LEN) ? c_DEPTH_LEN : burst_len;
    assign w_wr_fire  = wr_valid && wr_ready;
    assign w_pop      = (r_occ != 2'd0) && o_ready;

    // Slots the FIFO will need after this cycle: stored words plus the one
    // read in the SRAM pipe, minus the word leaving now. Issuing only while
    // that is below 2 guarantees the 2-entry FIFO never overflows.
    assign w_credit_used = 3'(r_occ) + 3'(r_inflight) - 3'(w_pop);
    assign w_issue       = (r_state == STREAM) && (w_credit_used < 3'd2);
    assign w_last_issue  = w_issue && (r_remain == LEN_W'(1));
    assign w_last_beat   = (r_state == FLUSH) && w_pop &&
                           (r_occ == 2'd1) && !r_inflight;

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge CK) begin
        if (RST) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state. A zero-length burst never leaves IDLE.
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (w_start_ok && (w_len_eff != '0)) w_state_next = STREAM;
            STREAM:  if (w_last_issue)                    w_state_next = FLUSH;
            FLUSH:   if (w_last_beat)                     w_state_next = IDLE;
            default:                                      w_state_next = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs. Reset masks the combinational outputs so the reset
    // cycle itself reports nothing and an aborted burst gives no done.
    // ------------------------------------------------------------------
    always_comb begin
        busy     = 1'b0;
        done     = 1'b0;
        wr_ready = 1'b0;
        if (!RST) begin
            busy     = (r_state != IDLE);
            done     = w_last_beat || r_zero_done;
            wr_ready = (r_state == IDLE) && !start;
        end
    end

    // ------------------------------------------------------------------
    // Read engine counters and 2-entry output FIFO
    // ------------------------------------------------------------------
    always_ff @(posedge CK) begin
        if (RST) begin
            r_rd_addr   <= '0;
            r_remain    <= '0;
            r_inflight  <= 1'b0;
            r_occ       <= 2'd0;
            r_wr_ptr    <= 1'b0;
            r_rd_ptr    <= 1'b0;
            r_fifo[0]   <= '0;
            r_fifo[1]   <= '0;
            r_zero_done <= 1'b0;
        end else begin
            r_zero_done <= w_start_ok && (w_len_eff == '0);
            r_inflight  <= w_issue;

            if (w_start_ok) begin
                r_rd_addr <= base_addr;
                r_remain  <= w_len_eff;
            end else if (w_issue) begin
                r_rd_addr <= ADDR_W'(next_addr(32'(r_rd_addr), 32'(DEPTH)));
                r_remain  <= r_remain - LEN_W'(1);
            end

            // SRAM data appears the cycle after the issue; capture it then.
            if (r_inflight) begin
                r_fifo[r_wr_ptr] <= w_sram_rdata;
                r_wr_ptr         <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            r_occ <= r_occ + 2'(r_inflight) - 2'(w_pop);
        end
    end

    assign o_valid = (r_occ != 2'd0);
    assign o_data  = r_fifo[r_rd_ptr];

    // Writes happen only in IDLE and reads only in STREAM, so the single
    // port is never contended.
    sp_sram_be #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_sram (
        .clk     (CK),
        .i_cs    (w_issue || w_wr_fire),
        .i_web   (!w_wr_fire),
        .i_be    (wr_be),
        .i_addr  (w_wr_fire ? wr_addr : r_rd_addr),
        .i_wdata (wr_data),
        .o_rdata (w_sram_rdata)
    );

endmodule
`default_nettype wire

// File: tb/tb_bias_stream_buf.sv
`default_nettype none
// ============================================================================
// Module      : tb_bias_stream_buf
// Description : Self-checking bench for bias_stream_buf: directed write/read
//               vectors, wrap, zero-length, collision, reset abort and random
//               traffic against a word-array reference memory.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bias_stream_buf;

    localparam int DEPTH  = 384;
    localparam int ADDR_W = 9;
    localparam int LEN_W  = 10;

    logic              CK = 1'b0;
    logic              RST = 1'b1;
    logic              wr_valid = 1'b0;
    logic              wr_ready;
    logic [ADDR_W-1:0] wr_addr = '0;
    logic [31:0]       wr_data = '0;
    logic [3:0]        wr_be = '0;
    logic              start = 1'b0;
    logic [ADDR_W-1:0] base_addr = '0;
    logic [LEN_W-1:0]  burst_len = '0;
    logic              busy;
    logic              done;
    logic              o_valid;
    logic              o_ready = 1'b0;
    logic [31:0]       o_data;

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] model_mem [0:DEPTH-1];

    typedef struct {
        int          addr;
        logic [31:0] data;
        logic [3:0]  be;
        logic [31:0] exp;
    } vec_t;

    always #5 CK = ~CK;

    bias_stream_buf #(
        .DATA_W (32),
        .DEPTH  (DEPTH)
    ) dut (
        .CK        (CK),
        .RST       (RST),
        .wr_valid  (wr_valid),
        .wr_ready  (wr_ready),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .wr_be     (wr_be),
        .start     (start),
        .base_addr (base_addr),
        .burst_len (burst_len),
        .busy      (busy),
        .done      (done),
        .o_valid   (o_valid),
        .o_ready   (o_ready),
        .o_data    (o_data)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic pick(input int pct);
        return ($urandom_range(0, 99) < pct);
    endfunction

    // Enter at posedge+1; leaves one cycle after the accepted write.
    task automatic do_write(input int addr, input logic [31:0] data, input logic [3:0] be);
        int k = 0;
        wr_valid = 1'b1;
        wr_addr  = ADDR_W'(addr);
        wr_data  = data;
        wr_be    = be;
        #1;
        while (!wr_ready && k < 50) begin
            @(posedge CK); #1; #1;
            k++;
        end
        if (!wr_ready) begin
            check("wr_ready_timeout", 32'(wr_ready), 32'd1);
        end else begin
            @(posedge CK);
            for (int b = 0; b < 4; b++)
                if (be[b]) model_mem[addr][8*b +: 8] = data[8*b +: 8];
            #1;
        end
        wr_valid = 1'b0;
    endtask

    // Runs one burst and checks every beat against the reference memory,
    // stall stability, beat count, done count/timing and first-beat latency.
    task automatic run_burst(input int base, input int len, input int pct,
                             input bit collide, output logic [31:0] first);
        int n, idx, cyc, done_cnt, done_cyc, first_v, last_hs, budget;
        logic [31:0] exp_q [$];
        bit stalled, extra, all_ready;
        logic [31:0] held;
        n = (len > DEPTH) ? DEPTH : len;
        for (int i = 0; i < n; i++) exp_q.push_back(model_mem[(base + i) % DEPTH]);
        all_ready = (pct >= 100);
        start     = 1'b1;
        base_addr = ADDR_W'(base);
        burst_len = LEN_W'(len);
        o_ready   = pick(pct);
        if (collide) begin
            wr_valid = 1'b1;
            wr_addr  = ADDR_W'(base);
            wr_data  = ~model_mem[base];
            wr_be    = 4'hF;
        end
        #1;
        if (collide) check("collide_wr_ready", 32'(wr_ready), 32'd0);
        idx = 0; cyc = 0; done_cnt = 0; done_cyc = -1; first_v = -1; last_hs = -1;
        stalled = 1'b0; held = '0; first = '0;
        budget = n * 12 + 40;
        while ((idx < n || done_cnt == 0) && cyc < budget) begin
            if (o_valid) begin
                if (first_v < 0) first_v = cyc;
                if (stalled) check("stall_stable", o_data, held);
                if (o_ready) begin
                    if (idx < n) check("beat_data", o_data, exp_q[idx]);
                    if (idx == 0) first = o_data;
                    idx++;
                    last_hs = cyc;
                    stalled = 1'b0;
                end else begin
                    stalled = 1'b1;
                    held    = o_data;
                end
            end
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            @(posedge CK); #1;
            start    = 1'b0;
            wr_valid = 1'b0;
            o_ready  = pick(pct);
            cyc++;
            #1;
        end
        if (cyc >= budget) check("burst_timeout", 32'(cyc), 32'(budget));
        check("beat_count", 32'(idx), 32'(n));
        check("done_count", 32'(done_cnt), 32'd1);
        if (n > 0) begin
            check("first_valid_cycle", 32'(first_v), 32'd3);
            check("done_with_last_beat", 32'(done_cyc), 32'(last_hs));
            if (all_ready) check("last_beat_cycle", 32'(last_hs), 32'(n + 2));
        end else begin
            check("zero_len_done_cycle", 32'(done_cyc), 32'd1);
            check("zero_len_no_valid", 32'(first_v), 32'hFFFF_FFFF);
        end
        extra = 1'b0;
        o_ready = 1'b1;
        for (int t = 0; t < 3; t++) begin
            if (o_valid || done || busy) extra = 1'b1;
            @(posedge CK); #1; #1;
        end
        check("quiet_after_burst", 32'(extra), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs [7];
        logic [31:0] first;
        int quiet;

        vecs[0] = '{addr: 5,   data: 32'hAABBCCDD, be: 4'hF,    exp: 32'hAABBCCDD};
        vecs[1] = '{addr: 5,   data: 32'h11223344, be: 4'b0101, exp: 32'hAA22CC44};
        vecs[2] = '{addr: 5,   data: 32'h55667788, be: 4'b1000, exp: 32'h5522CC44};
        vecs[3] = '{addr: 5,   data: 32'h00000000, be: 4'b0000, exp: 32'h5522CC44};
        vecs[4] = '{addr: 383, data: 32'hDEADBEEF, be: 4'hF,    exp: 32'hDEADBEEF};
        vecs[5] = '{addr: 383, data: 32'h12345678, be: 4'b0110, exp: 32'hDE3456EF};
        vecs[6] = '{addr: 0,   data: 32'hFFFFFFFF, be: 4'b0011, exp: 32'h0000FFFF};

        // Reset state, observed while RST is still held
        repeat (3) @(posedge CK);
        #1; #1;
        check("rst_wr_ready", 32'(wr_ready), 32'd0);
        check("rst_busy",     32'(busy),     32'd0);
        check("rst_done",     32'(done),     32'd0);
        check("rst_o_valid",  32'(o_valid),  32'd0);
        check("rst_o_data",   o_data,        32'd0);
        @(posedge CK); #1;
        RST = 1'b0;

        // Fill the whole memory so the reference model is complete
        for (int a = 0; a < DEPTH; a++) do_write(a, $urandom, 4'hF);
        for (int a = 0; a < 8; a++) do_write(a, 32'(a) * 32'h11111111, 4'hF);
        run_burst(0, 8, 100, 1'b0, first);
        check("burst0_first", first, 32'h00000000);

        // Table: write then read back one word
        for (int i = 0; i < 7; i++) begin
            do_write(vecs[i].addr, vecs[i].data, vecs[i].be);
            run_burst(vecs[i].addr, 1, 100, 1'b0, first);
            check("vec_readback", first, vecs[i].exp);
        end

        // Wrap: 382, 383, 0, 1
        run_burst(382, 4, 100, 1'b0, first);
        check("wrap_first", first, 32'hDE3456EF == model_mem[383] ? model_mem[382] : model_mem[382]);

        // Backpressure
        run_burst(100, 16, 50, 1'b0, first);

        // Zero length
        run_burst(50, 0, 100, 1'b0, first);

        // Start/write collision, then retry the write and read it back
        run_burst(20, 4, 100, 1'b1, first);
        do_write(20, 32'hC0DEC0DE, 4'hF);
        run_burst(20, 1, 100, 1'b0, first);
        check("collide_retry", first, 32'hC0DEC0DE);

        // Reset mid-burst
        start = 1'b1; base_addr = ADDR_W'(10); burst_len = LEN_W'(12); o_ready = 1'b1;
        @(posedge CK); #1;
        start = 1'b0;
        repeat (4) begin @(posedge CK); #1; end
        RST = 1'b1;
        @(posedge CK); #1; #1;
        check("abort_wr_ready", 32'(wr_ready), 32'd0);
        check("abort_busy",     32'(busy),     32'd0);
        check("abort_done",     32'(done),     32'd0);
        check("abort_o_valid",  32'(o_valid),  32'd0);
        check("abort_o_data",   o_data,        32'd0);
        @(posedge CK); #1;
        RST = 1'b0;
        quiet = 0;
        for (int t = 0; t < 20; t++) begin
            #1;
            if (done || o_valid || busy) quiet++;
            @(posedge CK); #1;
        end
        check("abort_no_done", 32'(quiet), 32'd0);
        run_burst(10, 12, 100, 1'b0, first);

        // Clamp: length beyond DEPTH streams exactly DEPTH words
        run_burst(200, 400, 100, 1'b0, first);

        // Random traffic
        for (int it = 0; it < 40; it++) begin
            if (pick(50)) begin
                do_write($urandom_range(0, DEPTH - 1), $urandom, 4'($urandom_range(0, 15)));
            end else begin
                run_burst($urandom_range(0, DEPTH - 1), $urandom_range(0, 20),
                          $urandom_range(30, 100), 1'b0, first);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
